// File: rtl/seg_pkg.sv
// Shared types and constants for the binary-to-BCD encoder and the display driver.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned BCD_W   = 10;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned SCR_W   = 16;
  localparam int unsigned NUM_DIG = SCR_W / DIG_W;
  localparam int unsigned MAX_MAG = 399;

  localparam logic [BCD_W-1:0] SAT_BCD = 10'h399;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import seg_pkg::*;
(
  input  logic [DIG_W-1:0] digit,
  output logic [DIG_W-1:0] adj_c
);

  assign adj_c = (digit >= DIG_W'(5)) ? DIG_W'(digit + DIG_W'(3)) : digit;

endmodule

// File: rtl/bin_to_bcd_encoder.sv
// Signed binary to 3-digit BCD magnitude converter, one bit per cycle (double dabble),
// with a latched sign and saturation to 399 on overflow.
module bin_to_bcd_encoder
  import seg_pkg::*;
#(
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  output logic              ready,
  output logic              done,
  output logic [BCD_W-1:0]  bcd_digit,
  output logic              sign,
  output logic              overflow
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  bin_q;
  logic [DATA_W-1:0]  mag_c;
  logic [SCR_W-1:0]   scr_q;
  logic [SCR_W-1:0]   scr_adj_c;
  logic [SCR_W-1:0]   scr_shift_c;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_lat_q;
  logic               ovf_lat_q;
  logic               accept_c;
  logic               last_c;

  // Two's-complement magnitude; the most negative value maps to 2^(DATA_W-1) unsigned.
  assign mag_c = value[DATA_W-1] ? DATA_W'(~value + DATA_W'(1)) : value;

  assign accept_c = (state_q == IDLE) && start;
  assign last_c   = (state_q == SHIFT) && (cnt_q == CNT_W'(DATA_W - 1));

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scr_q[g*DIG_W +: DIG_W]),
      .adj_c (scr_adj_c[g*DIG_W +: DIG_W])
    );
  end

  // Corrected scratch shifted left, pulling in the binary MSB.
  assign scr_shift_c = SCR_W'({scr_adj_c, bin_q[DATA_W-1]});

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready   <= (state_d == IDLE);
      done    <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      sign_lat_q <= 1'b0;
      ovf_lat_q  <= 1'b0;
      bcd_digit  <= '0;
      sign       <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept_c) begin
      bin_q      <= mag_c;
      scr_q      <= '0;
      cnt_q      <= '0;
      sign_lat_q <= value[DATA_W-1];
      ovf_lat_q  <= (32'(mag_c) > MAX_MAG);
    end else if (state_q == SHIFT) begin
      scr_q <= scr_shift_c;
      bin_q <= {bin_q[DATA_W-2:0], 1'b0};
      cnt_q <= CNT_W'(cnt_q + CNT_W'(1));
      if (last_c) begin
        bcd_digit <= ovf_lat_q ? SAT_BCD : scr_shift_c[BCD_W-1:0];
        sign      <= sign_lat_q;
        overflow  <= ovf_lat_q;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_encoder.sv
// Randomized self-checking bench for bin_to_bcd_encoder against an arithmetic reference.
module tb_bin_to_bcd_encoder;

  localparam int unsigned DATA_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] value;
  logic              ready;
  logic              done;
  logic [9:0]        bcd_digit;
  logic              sign;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;

  bin_to_bcd_encoder #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .value     (value),
    .ready     (ready),
    .done      (done),
    .bcd_digit (bcd_digit),
    .sign      (sign),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_int(input logic [DATA_W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [9:0] ref_bcd(input logic [DATA_W-1:0] v);
    int m;
    m = to_int(v);
    if (m < 0) m = -m;
    if (m > 399) return 10'h399;
    return 10'((m / 100) * 256 + ((m / 10) % 10) * 16 + (m % 10));
  endfunction

  function automatic logic ref_ovf(input logic [DATA_W-1:0] v);
    int m;
    m = to_int(v);
    if (m < 0) m = -m;
    return (m > 399);
  endfunction

  function automatic logic ref_sign(input logic [DATA_W-1:0] v);
    return (to_int(v) < 0);
  endfunction

  // One conversion; with scramble, start and value toggle randomly while busy.
  task automatic run_conv(input logic [DATA_W-1:0] v, input bit scramble);
    int lat;
    int w;
    @(negedge clk);
    w = 0;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 32'(ready), 1);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      if (scramble) begin
        start = 1'($urandom);
        value = DATA_W'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", 32'(lat), DATA_W);
    chk("bcd", 32'(bcd_digit), 32'(ref_bcd(v)));
    chk("sign", 32'(sign), 32'(ref_sign(v)));
    chk("ovf", 32'(overflow), 32'(ref_ovf(v)));
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 0);
    chk("ready_after_done", 32'(ready), 1);
    chk("bcd_hold", 32'(bcd_digit), 32'(ref_bcd(v)));
  endtask

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] dir_vals[6];

  initial begin
    int pulses;
    bit d1, d2;
    logic [DATA_W-1:0] ev;

    rst   = 1'b1;
    start = 1'b1;
    value = DATA_W'(257);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_outs", 32'({overflow, sign, bcd_digit}), 0);
    start = 1'b0;
    rst   = 1'b0;

    dir_vals = '{DATA_W'(257), DATA_W'(-45), DATA_W'(399), DATA_W'(400),
                 DATA_W'(-2048), DATA_W'(0)};
    foreach (dir_vals[i]) run_conv(dir_vals[i], 1'b0);

    for (int i = 0; i < 40; i++) begin
      if (i[0]) run_conv(DATA_W'($urandom_range(0, 4095)), 1'b1);
      else      run_conv(DATA_W'($urandom_range(0, 1000) - 500), 1'b1);
    end

    // Abort a conversion of 123 in its 5th shift cycle.
    run_conv(DATA_W'(257), 1'b0);
    @(negedge clk);
    start = 1'b1;
    value = DATA_W'(123);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("abort_done", 32'(done), 0);
    chk("abort_outs", 32'({overflow, sign, bcd_digit}), 0);
    chk("abort_ready", 32'(ready), 1);
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 0);
    run_conv(DATA_W'(123), 1'b0);

    // Zero result must hold while idle.
    run_conv(DATA_W'(0), 1'b0);
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("zero_hold", 32'({done, overflow, sign, bcd_digit}), 0);
    end

    // Back-to-back: start held high, value changing every cycle.
    d1 = 1'b0;
    d2 = 1'b0;
    start = 1'b1;
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) begin
        ev = exp_q.pop_front();
        chk("b2b_bcd", 32'(bcd_digit), 32'(ref_bcd(ev)));
        chk("b2b_sign", 32'(sign), 32'(ref_sign(ev)));
        chk("b2b_ovf", 32'(overflow), 32'(ref_ovf(ev)));
        pulses++;
      end
      if (d1) chk("b2b_gap_idle", 32'(ready), 1);
      if (d2) chk("b2b_gap_accept", 32'(ready), 0);
      d2 = d1;
      d1 = done;
      value = DATA_W'($urandom);
      if (ready) exp_q.push_back(value);
    end
    start = 1'b0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (done) begin
        ev = exp_q.pop_front();
        chk("b2b_bcd", 32'(bcd_digit), 32'(ref_bcd(ev)));
        chk("b2b_sign", 32'(sign), 32'(ref_sign(ev)));
        chk("b2b_ovf", 32'(overflow), 32'(ref_ovf(ev)));
        pulses++;
      end
    end
    chk("b2b_drained", 32'(exp_q.size()), 0);
    chk("b2b_count_ok", 32'(pulses >= 5), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_encoder.md
BIN_TO_BCD_ENCODER -- requirements
Module: bin_to_bcd_encoder

Interface
REQ-001 Parameter DATA_W, default 12: width of the signed two's-complement input value.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port start, input, 1: request to convert value; sampled only while ready=1.
REQ-005 Port value, input, DATA_W: signed binary value to convert.
REQ-006 Port ready, output, 1: high only in state IDLE.
REQ-007 Port done, output, 1: one-cycle pulse when new results are valid.
REQ-008 Port bcd_digit, output, 10: magnitude as 3 BCD digits. Bits [9:8] hold the hundreds digit (0-3), [7:4] the tens, [3:0] the ones.
REQ-009 Port sign, output, 1: 1 when the converted value was negative.
REQ-010 Port overflow, output, 1: 1 when the magnitude exceeded MAX_MAG (399).

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE, start=1 SHALL be accepted at edge E0 and the FSM SHALL move to SHIFT.
REQ-013 The accept edge E0 SHALL load:
- the magnitude |value| as DATA_W-bit unsigned into the binary shift register;
- a 16-bit BCD scratch register, cleared to 0;
- the iteration counter, cleared to 0;
- a latched sign = value[DATA_W-1];
- a latched overflow = (magnitude > 399).
REQ-014 On each SHIFT edge, every 4-bit scratch digit >= 5 SHALL first have 3 added (double dabble). Then {scratch, binary} SHALL shift left by 1 and the counter SHALL increment.
REQ-015 On the SHIFT edge where counter == DATA_W-1, the FSM SHALL enter DONE and register the results:
- bcd_digit, from the final scratch value (scratch[9:0]);
- sign and overflow, from their latched values.
REQ-016 When overflow=1, bcd_digit SHALL saturate to 10'b11_1001_1001 (399) instead of the scratch value.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-018 Latency: accept at E0; done is high in the cycle following edge E_DATA_W (12 cycles for the default width).
REQ-019 start SHALL be ignored in SHIFT and in DONE, and value changes after E0 SHALL have no effect.
REQ-020 bcd_digit, sign and overflow SHALL hold their values until the next DONE update.
REQ-021 Zero SHALL convert to sign=0, and the most negative input (-2^(DATA_W-1)) SHALL produce sign=1, overflow=1.
REQ-022 The scratch register SHALL be 16 bits wide so that intermediate digits never truncate for DATA_W <= 13.

Reset
REQ-023 When rst=1 at an edge, the block SHALL:
- enter IDLE;
- clear bcd_digit, sign, overflow, done, the counter and scratch to 0;
- be ready=1 in the following cycle.
REQ-024 A reset during SHIFT or DONE SHALL abort the conversion with no done pulse and no output update; rst has priority over start.

Structure
REQ-025 Package seg_pkg SHALL hold:
- the state enum (IDLE/SHIFT/DONE);
- BCD_W = 10;
- MAX_MAG = 399;
- SAT_BCD = 10'h399.
The display driver SHALL import these constants from the same package.
REQ-026 The per-digit add-3 correction SHALL be a single sub-module, bcd_digit_adj (4-bit in, 4-bit out), instantiated 4 times.

Verification
REQ-027 value=257, start pulse -> done exactly 12 cycles after accept; bcd_digit=10'h257, sign=0, overflow=0.
REQ-028 value=-45 (12'hFD3) -> bcd_digit=10'h045, sign=1, overflow=0.
REQ-029 value=399 -> 10'h399, overflow=0; value=400 -> 10'h399, overflow=1; value=-2048 -> 10'h399, sign=1, overflow=1.
REQ-030 start held high continuously with the value changing each cycle:
- only the values sampled in IDLE are converted;
- conversions run back-to-back with exactly one IDLE cycle between each DONE and the next accept.
REQ-031 rst pulsed during the 5th SHIFT cycle of converting 123 -> no done pulse; outputs 0; ready=1 in the next cycle; a following conversion of 123 yields 10'h123.
REQ-032 value=0 -> bcd_digit=0, sign=0, overflow=0; the outputs SHALL then hold stable for 20 idle cycles.
